rf_wb_sched: RTL
================

Name: rf_wb_sched

Overview:
- Write-back scheduler and scoreboard for the 32x32 three-port register file (one synchronous write port, two asynchronous read ports, r0 reads as zero).
- Shares the single write port between two write-back requesters (req0 = ALU, req1 = load/MEM) using round-robin arbitration.
- Tracks destination registers with in-flight writes and produces the issue-stall and read-stall signals for the decode stage.
- Drives the register file's wen/waddr/wdata directly from registered outputs.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width; the register count is 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode issues an instruction that will write issue_waddr.
- issue_waddr  in  ADDR_W  destination register of the issuing instruction.
- issue_ready  out  1  issue accepted this cycle.
- raddr1  in  ADDR_W  source register 1 of the instruction in decode.
- raddr2  in  ADDR_W  source register 2 of the instruction in decode.
- rd_stall  out  1  at least one source register has a pending write.
- req0_valid  in  1  ALU write-back request.
- req0_waddr  in  ADDR_W  ALU write-back destination.
- req0_wdata  in  DATA_W  ALU write-back data.
- req0_ready  out  1  ALU request granted.
- req1_valid  in  1  MEM write-back request.
- req1_waddr  in  ADDR_W  MEM write-back destination.
- req1_wdata  in  DATA_W  MEM write-back data.
- req1_ready  out  1  MEM request granted.
- rf_wen  out  1  register file write enable (registered).
- rf_waddr  out  ADDR_W  register file write address (registered).
- rf_wdata  out  DATA_W  register file write data (registered).
- busy_vec  out  2**ADDR_W  scoreboard; bit i set means register i has a pending write.

Behaviour:
- Reset (async, resetn=0):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - busy_vec=0.
  - Round-robin pointer last=1, so req0 wins the first conflict.
  - Any in-flight request is dropped; requesters re-present it after reset.
- Handshake rules:
  - A transfer occurs when valid&&ready at a rising edge.
  - A requester holds valid, waddr and wdata stable until ready.
  - ready is combinational from the valid inputs and the pointer; it never depends on ready itself.
- Arbitration:
  - Exactly one grant per cycle at most.
  - Only one requester valid: it is granted.
  - Both valid: grant req1 if last==0, else req0.
  - On any grant, last <= index of the granted requester.
  - No requester valid: pointer holds.
- Write stage, 1-cycle latency:
  - A transfer at edge N sets rf_waddr/rf_wdata from the winner, and rf_wen=1 during cycle N..N+1 only if waddr!=0.
  - The register file commits at edge N+1.
  - No transfer: rf_wen=0 and rf_waddr/rf_wdata hold.
  - Full throughput: back-to-back grants produce rf_wen=1 on consecutive cycles.
- Scoreboard:
  - Set: issue transfer with issue_waddr!=0 sets busy[issue_waddr].
  - issue_ready = (issue_waddr==0) || !busy[issue_waddr]. This is a WAW block and is evaluated on the current busy_vec, even if that register clears at the same edge.
  - Clear: at each edge with rf_wen=1, busy[rf_waddr] <= 0. The clear coincides with the register file commit, so a read in the next cycle returns the new value.
  - A set and a clear at the same edge on different registers both take effect. The same register cannot be both set and cleared at one edge because issue_ready blocks it.
  - A write-back to a non-busy register is written normally; busy_vec is unchanged.
  - busy[0] is constant 0.
- rd_stall = (raddr1!=0 && busy[raddr1]) || (raddr2!=0 && busy[raddr2]); combinational.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- When defined:
  - Adds outputs byp1_hit, byp2_hit (1 bit each) and byp_data (DATA_W).
  - bypN_hit = rf_wen && rf_waddr==raddrN && raddrN!=0.
  - byp_data = rf_wdata.
  - rd_stall ignores a source whose bypN_hit=1, so the consumer uses byp_data one cycle early.
- When undefined: these ports are absent and rd_stall follows the base equation above.

Test Plan:
- Reset then idle: busy_vec=0, rf_wen=0, issue_valid=1 with waddr=5 -> issue_ready=1; busy_vec=0x20 next cycle.
- req0 writes r5=0xDEADBEEF while busy[5]=1 -> rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF for one cycle; busy[5] clears at the following edge; raddr1=5 gives rd_stall=1 before the clear and 0 after.
- req0 and req1 valid for 4 cycles (r1..r4, r8..r11) -> grants alternate 0,1,0,1 starting with req0; rf_wen high for 4 consecutive cycles.
- Issue r7, then issue r7 again before its write-back -> second issue_ready=0 until the cycle after rf_wen with rf_waddr=7; write-back to r0 -> rf_wen=0, busy_vec unchanged.
- Assert resetn=0 mid-transfer with busy_vec=0x0000_0F00 and req1 valid -> outputs 0 immediately (async); after release, first conflict grants req0.
- With RF_WB_BYPASS_EN: busy[3]=1, rf_wen=1, rf_waddr=3, rf_wdata=0x12345678, raddr2=3 -> byp2_hit=1, byp_data=0x12345678, rd_stall=0.

Source files
------------

// File: rtl/rf_wb_sched.sv
// Write-back scheduler and scoreboard for a 32x32 register file: round-robin sharing of the write port,
// pending-write tracking, and decode stall generation. Optional forwarding path enabled by RF_WB_BYPASS_EN.
module rf_wb_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_waddr,
  output logic                     issue_ready,
  input  logic [ADDR_W-1:0]        raddr1,
  input  logic [ADDR_W-1:0]        raddr2,
  output logic                     rd_stall,
  input  logic                     req0_valid,
  input  logic [ADDR_W-1:0]        req0_waddr,
  input  logic [DATA_W-1:0]        req0_wdata,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [ADDR_W-1:0]        req1_waddr,
  input  logic [DATA_W-1:0]        req1_wdata,
  output logic                     req1_ready,
  output logic                     rf_wen,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
`ifdef RF_WB_BYPASS_EN
  output logic                     byp1_hit,
  output logic                     byp2_hit,
  output logic [DATA_W-1:0]        byp_data,
`endif
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int NREG = 2 ** ADDR_W;

  logic              last_q, last_d;
  logic              rf_wen_q, rf_wen_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              grant0, grant1;
  logic              src1_pend, src2_pend;

  // Arbitration: last_q names the previous winner, so the other side wins a conflict
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_q);
    grant1 = req1_valid && (!req0_valid || !last_q);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    last_d     = last_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant0) begin
      last_d     = 1'b0;
      rf_wen_d   = (req0_waddr != '0);
      rf_waddr_d = req0_waddr;
      rf_wdata_d = req0_wdata;
    end else if (grant1) begin
      last_d     = 1'b1;
      rf_wen_d   = (req1_waddr != '0);
      rf_waddr_d = req1_waddr;
      rf_wdata_d = req1_wdata;
    end
  end

  // WAW block looks at the current scoreboard, ignoring a clear landing this edge
  assign issue_ready = (issue_waddr == '0) || !busy_q[issue_waddr];

  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) busy_d[rf_waddr_q] = 1'b0;
    if (issue_valid && issue_ready && (issue_waddr != '0)) busy_d[issue_waddr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q     <= 1'b1;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      last_q     <= last_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy_vec = busy_q;

`ifdef RF_WB_BYPASS_EN
  // A source being written this cycle is forwarded instead of stalling
  assign byp1_hit  = rf_wen_q && (rf_waddr_q == raddr1) && (raddr1 != '0);
  assign byp2_hit  = rf_wen_q && (rf_waddr_q == raddr2) && (raddr2 != '0);
  assign byp_data  = rf_wdata_q;
  assign src1_pend = (raddr1 != '0) && busy_q[raddr1] && !byp1_hit;
  assign src2_pend = (raddr2 != '0) && busy_q[raddr2] && !byp2_hit;
`else
  assign src1_pend = (raddr1 != '0) && busy_q[raddr1];
  assign src2_pend = (raddr2 != '0) && busy_q[raddr2];
`endif

  assign rd_stall = src1_pend || src2_pend;

endmodule
